// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin sharing of one UART TX among N_REQ byte-stream requesters.
// Optional idle-owner watchdog is built in when TXARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DW             = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    send,
    input  logic [N_REQ*DW-1:0] data,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    req_busy,
    output logic [DW-1:0]       uart_tx_data,
    output logic                uart_tx_send,
    input  logic                uart_tx_busy,
    output logic                timeout_flag
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StOwn, StInflight} state_e;

    state_e           state_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    owner_q;
    logic             seen_busy_q;
    logic [1:0]       infl_cnt_q;

    logic [N_REQ-1:0] eligible;
    logic             pick_valid;
    logic             hi_valid;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    hi_idx;
    logic [IW-1:0]    lo_idx;
    logic             own_req;
    logic             own_send;
    logic             launch;
    logic             release_own;
    logic             timeout_hit;
    logic [DW-1:0]    own_data;
    logic [IW-1:0]    next_ptr;

`ifdef TXARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]    to_cnt_q;
    logic [N_REQ-1:0] mask_q;

    assign timeout_hit = (state_q == StOwn) && !launch && own_req &&
                         (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign eligible    = req & ~mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            mask_q   <= '0;
        end else begin
            // An offender stays masked only until it lets go of req.
            mask_q <= (mask_q & req) | (timeout_hit ? grant : '0);
            if (state_q == StIdle || launch) begin
                to_cnt_q <= '0;
            end else if (state_q == StOwn) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign eligible    = req;
`endif

    // Rotating priority: lowest eligible index at or above rr_ptr, else lowest overall.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_idx = IW'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_valid = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        pick_valid = |eligible;
        pick_idx   = hi_valid ? hi_idx : lo_idx;
    end

    always_comb begin
        own_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                own_data = data[i*DW +: DW];
            end
        end
    end

    assign own_req     = |(req & grant);
    assign own_send    = |(send & grant);
    assign launch      = (state_q == StOwn) && own_send && !uart_tx_busy;
    assign release_own = (state_q == StOwn) && !launch && (!own_req || timeout_hit);
    assign next_ptr    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Only the owner, while not in flight, sees the real UART busy.
    assign req_busy = (state_q == StOwn) ? (~grant | ({N_REQ{uart_tx_busy}} & grant)) : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant        <= '0;
            uart_tx_data <= '0;
            uart_tx_send <= 1'b0;
            timeout_flag <= 1'b0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            seen_busy_q  <= 1'b0;
            infl_cnt_q   <= '0;
        end else begin
            uart_tx_send <= 1'b0;
            timeout_flag <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner_q <= pick_idx;
                        state_q <= StOwn;
                    end
                end
                StOwn: begin
                    if (launch) begin
                        uart_tx_data <= own_data;
                        uart_tx_send <= 1'b1;
                        seen_busy_q  <= 1'b0;
                        infl_cnt_q   <= '0;
                        state_q      <= StInflight;
                    end else if (release_own) begin
                        grant        <= '0;
                        rr_ptr_q     <= next_ptr;
                        timeout_flag <= timeout_hit;
                        state_q      <= StIdle;
                    end
                end
                StInflight: begin
                    if (uart_tx_busy) begin
                        seen_busy_q <= 1'b1;
                    end
                    if (infl_cnt_q != 2'd3) begin
                        infl_cnt_q <= infl_cnt_q + 1'b1;
                    end
                    // A UART that never raises busy is released after four cycles.
                    if (!uart_tx_busy && (seen_busy_q || infl_cnt_q == 2'd3)) begin
                        state_q <= StOwn;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a simple UART busy model.
// Define TXARB_TIMEOUT_EN for both DUT and bench to also exercise the watchdog.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    send;
    logic [N*DW-1:0] data;
    logic [N-1:0]    grant;
    logic [N-1:0]    req_busy;
    logic [DW-1:0]   uart_tx_data;
    logic            uart_tx_send;
    logic            uart_tx_busy;
    logic            timeout_flag;

    int checks   = 0;
    int failures = 0;
    int model_ptr;

    logic [DW-1:0] exp_bytes[$];
    logic [N-1:0]  exp_grants[$];

    uart_tx_arbiter #(
        .N_REQ          (N),
        .DW             (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .send         (send),
        .data         (data),
        .grant        (grant),
        .req_busy     (req_busy),
        .uart_tx_data (uart_tx_data),
        .uart_tx_send (uart_tx_send),
        .uart_tx_busy (uart_tx_busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    function automatic void check_eq(input string name, input logic [63:0] act,
                                     input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference arbitration: first requester found walking up from ptr, wrapping.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int ptr);
        logic [N-1:0] one;
        for (int off = 0; off < N; off++) begin
            if (r[(ptr + off) % N]) begin
                one = '0;
                one[(ptr + off) % N] = 1'b1;
                return one;
            end
        end
        return '0;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART stand-in: usually busy for a few cycles, sometimes never busy at all.
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_send && $urandom_range(0, 3) != 0) begin
                uart_tx_busy = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                uart_tx_busy = 1'b0;
            end
        end
    end

    // Monitor: pops expected bytes on each launch and expected owners on each new grant.
    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        if (uart_tx_send) begin
            if (exp_bytes.size() == 0) begin
                check_eq("unexpected_launch", uart_tx_data, 64'hdead);
            end else begin
                check_eq("tx_byte", uart_tx_data, exp_bytes.pop_front());
            end
        end
        check_eq("grant_onehot", $onehot0(grant), 1);
        if (grant != prev_grant && prev_grant != '0 && grant != '0) begin
            check_eq("owner_to_owner", grant, '0);
        end
        if (prev_grant == '0 && grant != '0) begin
            if (exp_grants.size() == 0) begin
                check_eq("unexpected_grant", grant, '0);
            end else begin
                check_eq("grant_owner", grant, exp_grants.pop_front());
            end
        end
        check_eq("req_busy_others", req_busy | grant, {N{1'b1}});
`ifndef TXARB_TIMEOUT_EN
        check_eq("no_timeout", timeout_flag, 0);
`endif
        prev_grant = grant;
    end

    // One packet from the model's chosen owner; DUT must be idle on entry.
    task automatic do_packet(output bit ok, output int g_act);
        logic [N-1:0]  exp_g;
        int            g;
        int            n;
        int            waited;
        int            other;
        ok    = 1'b0;
        g_act = -1;
        exp_g = rr_pick(req, model_ptr);
        exp_grants.push_back(exp_g);
        g      = idx_of(exp_g);
        waited = 0;
        while (grant == '0 && waited < 10) begin
            tick();
            waited++;
        end
        if (grant == '0) begin
            check_eq("grant_timeout", grant, exp_g);
            return;
        end
        g_act = idx_of(grant);
        n     = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (req_busy[g] && waited < 30) begin
                tick();
                waited++;
            end
            if (req_busy[g]) begin
                check_eq("busy_timeout", req_busy[g], 0);
                return;
            end
            repeat ($urandom_range(0, 2)) tick();
            for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
            send    = '0;
            send[g] = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                other       = (g + $urandom_range(1, N - 1)) % N;
                send[other] = 1'b1;
            end
            exp_bytes.push_back(data[g*DW +: DW]);
            if (k == n - 1 && $urandom_range(0, 3) == 0) req[g] = 1'b0;
            tick();
            send = '0;
            check_eq("launch_latency", uart_tx_send, 1);
            if ($urandom_range(0, 2) == 0) begin
                send[g] = 1'b1;
                tick();
                send = '0;
            end
        end
        if (req[g]) begin
            repeat ($urandom_range(0, 3)) tick();
            req[g] = 1'b0;
            if ($urandom_range(0, 1) == 1) req = req | (N'($urandom) & ~(N'(1) << g));
        end
        waited = 0;
        while (grant != '0 && waited < 30) begin
            tick();
            waited++;
        end
        if (grant != '0) begin
            check_eq("release_timeout", grant, '0);
            return;
        end
        model_ptr = (g + 1) % N;
        ok        = 1'b1;
    endtask

    task automatic random_packets(input int count, inout bit ok);
        int g;
        for (int p = 0; p < count && ok; p++) begin
            req = req | (N'($urandom) & N'($urandom));
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            do_packet(ok, g);
        end
    endtask

    initial begin
        bit ok;
        int g;
        int waited;
        rst_n     = 1'b0;
        req       = '0;
        send      = '0;
        data      = '0;
        model_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_grant", grant, '0);
        check_eq("reset_req_busy", req_busy, {N{1'b1}});
        check_eq("reset_send", uart_tx_send, 0);
        check_eq("reset_data", uart_tx_data, 0);
        rst_n = 1'b1;
        tick();

        ok = 1'b1;
        for (int k = 0; k < 5 && ok; k++) begin
            req = '1;
            do_packet(ok, g);
            if (ok) check_eq("rr_order", g, k % N);
        end

        random_packets(25, ok);

        // Reset while a byte is in flight.
        if (ok) begin
            req = 4'b0001;
            exp_grants.push_back(rr_pick(req, model_ptr));
            waited = 0;
            while ((grant == '0 || req_busy[0]) && waited < 30) begin
                tick();
                waited++;
            end
            check_eq("pre_reset_owner", grant, 4'b0001);
            data    = {4{8'h5a}};
            send[0] = 1'b1;
            tick();
            send = '0;
            check_eq("pre_reset_launch", uart_tx_send, 1);
            #1 rst_n = 1'b0;
            #1;
            check_eq("async_reset_grant", grant, '0);
            check_eq("async_reset_send", uart_tx_send, 0);
            check_eq("async_reset_req_busy", req_busy, {N{1'b1}});
            req = '0;
            tick();
            tick();
            rst_n     = 1'b1;
            model_ptr = 0;
            repeat (3) begin
                tick();
                check_eq("idle_after_reset", grant, '0);
            end
            req = 4'b0100;
            do_packet(ok, g);
            if (ok) check_eq("single_owner", g, 2);
        end

        random_packets(25, ok);

`ifdef TXARB_TIMEOUT_EN
        if (ok) begin
            bit seen;
            req = 4'b0010;
            exp_grants.push_back(rr_pick(req, model_ptr));
            tick();
            check_eq("to_grant", grant, 4'b0010);
            seen   = 1'b0;
            waited = 0;
            while (!seen && waited < 40) begin
                tick();
                waited++;
                seen = timeout_flag;
            end
            check_eq("timeout_flag", seen, 1);
            check_eq("timeout_release", grant, '0);
            repeat (3) begin
                tick();
                check_eq("masked_owner", grant, '0);
            end
            model_ptr = 2;
            req[2]    = 1'b1;
            do_packet(ok, g);
            if (ok) check_eq("after_timeout_owner", g, 2);
            if (ok) begin
                req[1] = 1'b0;
                tick();
                req[1] = 1'b1;
                do_packet(ok, g);
                if (ok) check_eq("unmasked_owner", g, 1);
            end
        end
`endif

        req = '0;
        repeat (3) tick();
        check_eq("bytes_left", exp_bytes.size(), 0);
        check_eq("grants_left", exp_grants.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
